// File: rtl/send_arbiter.sv
// Round-robin arbiter that moves one producer's packet at a time into the shared send ring.
// Once the packet's last byte is taken, its saturated length is posted to the length fifo.
module send_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned LEN_BITS = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    output logic [NREQ-1:0]       gnt,
    input  logic [8*NREQ-1:0]     req_data,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic [7:0]            send_ring_data,
    output logic                  send_ring_wr_en,
    input  logic                  send_ring_full,
    output logic [LEN_BITS-1:0]   send_fifo_data,
    output logic                  send_fifo_wr_en,
    input  logic                  send_fifo_full,
    input  logic                  clr,
    output logic                  overflow,
    output logic                  busy
);

    localparam int unsigned         PtrW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [LEN_BITS-1:0] MaxLen = '1;

    typedef enum logic [1:0] {StIdle, StXfer, StCommit} state_e;

    state_e              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic [LEN_BITS-1:0] cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    logic                win_found;
    logic [PtrW-1:0]     win_idx;
    logic [NREQ-1:0]     win_oh;
    logic                sel_valid;
    logic                sel_last;
    logic [7:0]          sel_data;
    logic                accept;
    logic                ovf_set;

    // First requester at or after ptr, wrapping around.
    always_comb begin : arb_search
        logic [PtrW-1:0] idx;
        idx       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PtrW'((32'(ptr_q) + k) % NREQ);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    assign sel_valid = |(req_valid & gnt_q);
    assign sel_last  = |(req_last & gnt_q);

    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        ptr_d           = ptr_q;
        cnt_d           = cnt_q;
        req_ready       = '0;
        send_ring_wr_en = 1'b0;
        send_fifo_wr_en = 1'b0;
        accept          = 1'b0;
        ovf_set         = 1'b0;
        unique case (state_q)
            StIdle: begin
                gnt_d = '0;
                if (win_found) begin
                    state_d = StXfer;
                    gnt_d   = win_oh;
                    ptr_d   = (win_idx == PtrW'(NREQ - 1)) ? '0 : win_idx + PtrW'(1);
                    cnt_d   = '0;
                end
            end
            StXfer: begin
                req_ready = send_ring_full ? '0 : gnt_q;
                accept    = sel_valid && !send_ring_full;
                if (accept) begin
                    // Bytes past MaxLen are swallowed so the producer can still finish.
                    if (cnt_q != MaxLen) begin
                        send_ring_wr_en = 1'b1;
                        cnt_d           = cnt_q + LEN_BITS'(1);
                    end else begin
                        ovf_set = 1'b1;
                    end
                    if (sel_last) begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                if (!send_fifo_full) begin
                    send_fifo_wr_en = 1'b1;
                    state_d         = StIdle;
                    gnt_d           = '0;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // A new overflow wins over a simultaneous clear.
    assign ovf_d = (ovf_q & ~clr) | ovf_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign gnt            = gnt_q;
    assign send_ring_data = sel_data;
    assign send_fifo_data = cnt_q;
    assign overflow       = ovf_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_send_arbiter.sv
// Bench for send_arbiter: producers replay queued packets; a packet-level model predicts
// grants, ring bytes, length entries and overflow every cycle.
module tb_send_arbiter;
    localparam int NREQ      = 4;
    localparam int LEN_BITS  = 7;
    localparam int MAXL      = (1 << LEN_BITS) - 1;
    localparam int PH_IDLE   = 0;
    localparam int PH_SEND   = 1;
    localparam int PH_COMMIT = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ-1:0]     gnt;
    logic [8*NREQ-1:0]   req_data = '0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_last = '0;
    logic [NREQ-1:0]     req_ready;
    logic [7:0]          send_ring_data;
    logic                send_ring_wr_en;
    logic                send_ring_full = 1'b0;
    logic [LEN_BITS-1:0] send_fifo_data;
    logic                send_fifo_wr_en;
    logic                send_fifo_full = 1'b0;
    logic                clr = 1'b0;
    logic                overflow;
    logic                busy;

    send_arbiter #(.NREQ(NREQ), .LEN_BITS(LEN_BITS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .gnt             (gnt),
        .req_data        (req_data),
        .req_valid       (req_valid),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .send_ring_data  (send_ring_data),
        .send_ring_wr_en (send_ring_wr_en),
        .send_ring_full  (send_ring_full),
        .send_fifo_data  (send_fifo_data),
        .send_fifo_wr_en (send_fifo_wr_en),
        .send_fifo_full  (send_fifo_full),
        .clr             (clr),
        .overflow        (overflow),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Pending packets per producer: bytes flat in byte_q, lengths in len_q.
    logic [7:0] byte_q [NREQ][$];
    int         len_q  [NREQ][$];
    int         pos    [NREQ];

    int valid_pct = 100, full_pct = 0, ffull_pct = 0, clr_pct = 0;
    int full_ovr = -1, ffull_ovr = -1, clr_ovr = -1;

    // Packet-level model.
    int ph = PH_IDLE, cur = 0, mptr = 0, cur_len = 0;
    bit movf = 1'b0;

    logic [7:0]      ring_log [$];
    int              ring_cyc [$];
    int              fifo_log [$];
    int              gnt_log  [$];
    int              cyc = 0;
    logic [NREQ-1:0] prev_gnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += len_q[i].size();
        return n;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic add_rand(input int p, input int len);
        for (int k = 0; k < len; k++) byte_q[p].push_back(8'($urandom));
        len_q[p].push_back(len);
    endtask

    task automatic clear_logs();
        ring_log.delete();
        ring_cyc.delete();
        fifo_log.delete();
        gnt_log.delete();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (!(ph == PH_IDLE && pending() == 0) && k < budget) begin
            tick(1);
            k++;
        end
        check({name, "_idle_timeout"}, 32'(k < budget), 1);
    endtask

    task automatic wait_pos(input string name, input int p, input int n);
        int k = 0;
        while (pos[p] < n && k < 300) begin
            tick(1);
            k++;
        end
        check({name, "_pos_timeout"}, 32'(k < 300), 1);
    endtask

    // Producer / environment driver, one update just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (len_q[i].size() != 0);
            if (gnt[i] && len_q[i].size() != 0) begin
                req_valid[i]       = ($urandom_range(99) < valid_pct);
                req_data[8*i +: 8] = byte_q[i][0];
                req_last[i]        = (pos[i] == len_q[i][0] - 1);
            end else begin
                req_valid[i]       = 1'($urandom_range(1));
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom_range(1));
            end
        end
        send_ring_full = (full_ovr >= 0) ? (full_ovr != 0) : ($urandom_range(99) < full_pct);
        send_fifo_full = (ffull_ovr >= 0) ? (ffull_ovr != 0) : ($urandom_range(99) < ffull_pct);
        clr            = (clr_ovr >= 0) ? (clr_ovr != 0) : ($urandom_range(99) < clr_pct);
    end

    // Compare process: check this cycle's outputs, then advance the model over the next edge.
    initial forever begin
        logic [31:0] exp_gnt, exp_ready;
        bit          acc, exp_wr, exp_fwr, set, last, found;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            check("rst_gnt", gnt, 0);
            check("rst_busy", busy, 0);
            check("rst_ready", req_ready, 0);
            check("rst_ring_wr", send_ring_wr_en, 0);
            check("rst_fifo_wr", send_fifo_wr_en, 0);
            check("rst_overflow", overflow, 0);
            ph = PH_IDLE;
            mptr = 0;
            movf = 1'b0;
            prev_gnt = '0;
            for (int i = 0; i < NREQ; i++) begin
                byte_q[i].delete();
                len_q[i].delete();
                pos[i] = 0;
            end
        end else begin
            exp_gnt   = (ph == PH_IDLE) ? 32'd0 : (32'd1 << cur);
            exp_ready = (ph == PH_SEND && !send_ring_full) ? (32'd1 << cur) : 32'd0;
            acc       = (ph == PH_SEND) && !send_ring_full && req_valid[cur];
            exp_wr    = acc && (pos[cur] < MAXL);
            exp_fwr   = (ph == PH_COMMIT) && !send_fifo_full;
            check("gnt", gnt, exp_gnt);
            check("busy", busy, 32'(ph != PH_IDLE));
            check("req_ready", req_ready, exp_ready);
            check("ring_wr_en", send_ring_wr_en, 32'(exp_wr));
            if (exp_wr) check("ring_data", send_ring_data, byte_q[cur][0]);
            check("fifo_wr_en", send_fifo_wr_en, 32'(exp_fwr));
            if (exp_fwr) check("fifo_data", send_fifo_data, cur_len);
            check("overflow", overflow, 32'(movf));

            if (send_ring_wr_en) begin
                ring_log.push_back(send_ring_data);
                ring_cyc.push_back(cyc);
            end
            if (send_fifo_wr_en) fifo_log.push_back(int'(send_fifo_data));
            if (gnt != 0 && prev_gnt == 0) begin
                for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
            end
            prev_gnt = gnt;

            set = 1'b0;
            case (ph)
                PH_IDLE: begin
                    if (req != 0) begin
                        found = 1'b0;
                        for (int k = 0; k < NREQ; k++) begin
                            int idx;
                            idx = (mptr + k) % NREQ;
                            if (!found && req[idx]) begin
                                found = 1'b1;
                                cur = idx;
                            end
                        end
                        mptr = (cur + 1) % NREQ;
                        cur_len = (len_q[cur][0] > MAXL) ? MAXL : len_q[cur][0];
                        ph = PH_SEND;
                    end
                end
                PH_SEND: begin
                    if (acc) begin
                        if (pos[cur] >= MAXL) set = 1'b1;
                        last = (pos[cur] == len_q[cur][0] - 1);
                        void'(byte_q[cur].pop_front());
                        pos[cur]++;
                        if (last) begin
                            void'(len_q[cur].pop_front());
                            pos[cur] = 0;
                            ph = PH_COMMIT;
                        end
                    end
                end
                default: begin
                    if (!send_fifo_full) ph = PH_IDLE;
                end
            endcase
            movf = (movf && !clr) || set;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp036 [5] = '{0, 1, 2, 3, 0};
        int nfifo;
        logic [7:0] b037 [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

        #1 rst_n = 1'b0;
        #1;
        check("reset_gnt_now", gnt, 0);
        check("reset_busy_now", busy, 0);
        tick(2);
        rst_n = 1'b1;

        // Round-robin over four continuously requesting producers, 1-byte packets.
        clear_logs();
        for (int p = 0; p < NREQ; p++) begin
            add_rand(p, 1);
            add_rand(p, 1);
        end
        wait_idle("rr", 200);
        check("rr_grants", gnt_log.size(), 8);
        if (gnt_log.size() >= 5)
            for (int k = 0; k < 5; k++) check("rr_order", gnt_log[k], exp036[k]);
        check("rr_fifo_n", fifo_log.size(), 8);
        foreach (fifo_log[k]) check("rr_fifo_len", fifo_log[k], 1);

        // Three-byte packet from producer 0.
        clear_logs();
        byte_q[0].push_back(8'h11);
        byte_q[0].push_back(8'h22);
        byte_q[0].push_back(8'h33);
        len_q[0].push_back(3);
        wait_idle("p3", 100);
        check("p3_ring_n", ring_log.size(), 3);
        if (ring_log.size() == 3) begin
            check("p3_b0", ring_log[0], 8'h11);
            check("p3_b1", ring_log[1], 8'h22);
            check("p3_b2", ring_log[2], 8'h33);
            check("p3_consec01", ring_cyc[1] - ring_cyc[0], 1);
            check("p3_consec12", ring_cyc[2] - ring_cyc[1], 1);
        end
        check("p3_fifo_n", fifo_log.size(), 1);
        if (fifo_log.size() == 1) check("p3_fifo_len", fifo_log[0], 3);

        // Ring full for two cycles mid-packet.
        clear_logs();
        full_ovr = 0;
        foreach (b037[k]) byte_q[1].push_back(b037[k]);
        len_q[1].push_back(5);
        wait_pos("rf", 1, 2);
        full_ovr = 1;
        repeat (2) begin
            tick(1);
            check("rf_ready_low", req_ready, 0);
            check("rf_no_write", send_ring_wr_en, 0);
        end
        full_ovr = 0;
        wait_idle("rf", 100);
        check("rf_ring_n", ring_log.size(), 5);
        if (ring_log.size() == 5)
            foreach (b037[k]) check("rf_byte", ring_log[k], b037[k]);
        check("rf_fifo_n", fifo_log.size(), 1);
        if (fifo_log.size() == 1) check("rf_fifo_len", fifo_log[0], 5);

        // Length fifo full while committing.
        clear_logs();
        ffull_ovr = 1;
        add_rand(3, 2);
        begin
            int k = 0;
            while (ph != PH_COMMIT && k < 100) begin
                tick(1);
                k++;
            end
            check("ff_commit_timeout", 32'(k < 100), 1);
        end
        repeat (3) begin
            tick(1);
            check("ff_hold_gnt", gnt, 4'b1000);
            check("ff_hold_busy", busy, 1);
            check("ff_no_fifo_wr", send_fifo_wr_en, 0);
        end
        ffull_ovr = 0;
        tick(1);
        check("ff_fifo_wr", send_fifo_wr_en, 1);
        check("ff_fifo_data", send_fifo_data, 2);
        tick(1);
        check("ff_gnt_clear", gnt, 0);
        ffull_ovr = -1;

        // 130-byte packet saturates at 127 and sets overflow; clr drops it.
        clear_logs();
        add_rand(2, 130);
        wait_idle("ovf", 1000);
        check("ovf_ring_n", ring_log.size(), 127);
        check("ovf_fifo_n", fifo_log.size(), 1);
        if (fifo_log.size() == 1) check("ovf_fifo_len", fifo_log[0], 127);
        check("ovf_set", overflow, 1);
        clr_ovr = 1;
        tick(1);
        clr_ovr = -1;
        tick(1);
        check("ovf_cleared", overflow, 0);

        // Reset in the middle of a 5-byte packet.
        clear_logs();
        add_rand(1, 5);
        wait_pos("mr", 1, 2);
        nfifo = fifo_log.size();
        rst_n = 1'b0;
        #1;
        check("mr_gnt_now", gnt, 0);
        check("mr_busy_now", busy, 0);
        check("mr_ready_now", req_ready, 0);
        check("mr_ring_wr_now", send_ring_wr_en, 0);
        check("mr_fifo_wr_now", send_fifo_wr_en, 0);
        tick(2);
        rst_n = 1'b1;
        check("mr_no_fifo", fifo_log.size(), nfifo);
        clear_logs();
        add_rand(2, 1);
        add_rand(3, 1);
        wait_idle("mr", 100);
        check("mr_grants", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check("mr_first_grant", gnt_log[0], 2);
            check("mr_second_grant", gnt_log[1], 3);
        end
        check("mr_fifo_n", fifo_log.size(), 2);

        // Randomized traffic with backpressure, clears and one reset.
        valid_pct = 70;
        full_pct  = 20;
        ffull_pct = 30;
        clr_pct   = 5;
        full_ovr  = -1;
        for (int it = 0; it < 400; it++) begin
            tick(1);
            if (it == 200) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            if ($urandom_range(99) < 25) begin
                if ($urandom_range(39) == 0) add_rand(int'($urandom_range(NREQ - 1)),
                                                      125 + int'($urandom_range(7)));
                else add_rand(int'($urandom_range(NREQ - 1)), 1 + int'($urandom_range(9)));
            end
        end
        wait_idle("rand", 20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
